// File: rtl/pwm_ctrl_pkg.sv
// Shared types and constants for the PWM speed control front end.
// Speed is a 3-bit value; the FSM ramps it one step per prescaler tick.
package pwm_ctrl_pkg;

  localparam int SPEED_W = 3;
  localparam logic [SPEED_W-1:0] SPEED_MAX = 3'd7;

  typedef enum logic [1:0] {
    OFF     = 2'd0,
    RAMP_UP = 2'd1,
    RUN     = 2'd2,
    RAMP_DN = 2'd3
  } state_e;

  // One step from cur toward tgt; returns cur unchanged when already equal.
  function automatic logic [SPEED_W-1:0] step_toward(input logic [SPEED_W-1:0] cur,
                                                     input logic [SPEED_W-1:0] tgt);
    if (cur < tgt) begin
      return cur + 3'd1;
    end else if (cur > tgt) begin
      return cur - 3'd1;
    end
    return cur;
  endfunction

endpackage

// File: rtl/pwm_speed_ctrl_if.sv
// Button inputs and PWM-generator-facing outputs of the speed controller.
// The controller takes the slave side; whoever drives the buttons takes master.
interface pwm_speed_ctrl_if;

  logic                               btn_up;
  logic                               btn_dn;
  logic                               btn_run;
  logic [pwm_ctrl_pkg::SPEED_W-1:0]   speed;
  logic                               enable;
  logic [pwm_ctrl_pkg::SPEED_W-1:0]   target;
  logic                               busy;

  modport master (
    output btn_up, btn_dn, btn_run,
    input  speed, enable, target, busy
  );

  modport slave (
    input  btn_up, btn_dn, btn_run,
    output speed, enable, target, busy
  );

endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, counting debouncer and rising-edge pulse for one raw button.
// A clean input edge yields a registered 1-cycle pulse DEB_CYCLES+2 cycles later.
module btn_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena_i,
  input  logic btn_i,
  output logic pulse_o
);

  localparam logic [7:0] CNT_LAST = 8'(DEB_CYCLES - 1);

  logic       sync1_q;
  logic       sync2_q;
  logic       level_q;
  logic       level_d;
  logic       pulse_q;
  logic       pulse_d;
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    if (ena_i) begin
      if (sync2_q == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        cnt_d   = '0;
        pulse_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  // Synchronizer keeps sampling even while the rest of the block is frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/pwm_speed_ctrl.sv
// Button-driven target speed with soft start/stop ramp feeding the PWM generator.
// Outputs are registered; speed moves one step every RAMP_DIV cycles toward its goal.
module pwm_speed_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = 16,
  parameter int RAMP_DIV   = 256,
  parameter int TARGET_RST = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  pwm_speed_ctrl_if.slave      bus
);

  localparam logic [15:0] PRESC_LAST = 16'(RAMP_DIV - 1);

  logic               up_pls;
  logic               dn_pls;
  logic               run_pls;
  logic               tick;
  state_e             state_q, state_d;
  logic [SPEED_W-1:0] speed_q, speed_d;
  logic [SPEED_W-1:0] target_q, target_d;
  logic [15:0]        presc_q, presc_d;
  logic               enable_q, enable_d;
  logic               busy_q, busy_d;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
    .clk(clk), .rst_n(rst_n), .ena_i(ena), .btn_i(bus.btn_up), .pulse_o(up_pls)
  );
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dn (
    .clk(clk), .rst_n(rst_n), .ena_i(ena), .btn_i(bus.btn_dn), .pulse_o(dn_pls)
  );
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_run (
    .clk(clk), .rst_n(rst_n), .ena_i(ena), .btn_i(bus.btn_run), .pulse_o(run_pls)
  );

  assign tick = (presc_q == PRESC_LAST);

  always_comb begin
    target_d = target_q;
    state_d  = state_q;
    speed_d  = speed_q;
    presc_d  = presc_q;
    if (ena) begin
      if (up_pls && !dn_pls && target_q != SPEED_MAX) begin
        target_d = target_q + 3'd1;
      end else if (dn_pls && !up_pls && target_q != '0) begin
        target_d = target_q - 3'd1;
      end

      // A run pulse always wins over a same-cycle tick: the step is dropped.
      unique case (state_q)
        OFF: begin
          speed_d = '0;
          if (run_pls) state_d = (target_q == '0) ? RUN : RAMP_UP;
        end
        RAMP_UP: begin
          if (run_pls) begin
            state_d = RAMP_DN;
          end else if (tick) begin
            speed_d = step_toward(speed_q, target_q);
            if (step_toward(speed_q, target_q) == target_q) state_d = RUN;
          end
        end
        RUN: begin
          if (run_pls) begin
            state_d = RAMP_DN;
          end else if (tick) begin
            speed_d = step_toward(speed_q, target_q);
          end
        end
        RAMP_DN: begin
          if (run_pls) begin
            state_d = RAMP_UP;
          end else if (speed_q == '0) begin
            state_d = OFF;
          end else if (tick) begin
            speed_d = speed_q - 3'd1;
            if (speed_q == 3'd1) state_d = OFF;
          end
        end
        default: state_d = OFF;
      endcase

      if (state_d != state_q || (state_q == RUN && speed_q == target_q) || tick) begin
        presc_d = '0;
      end else begin
        presc_d = presc_q + 16'd1;
      end
    end
    enable_d = (state_d != OFF);
    busy_d   = (state_d == RAMP_DN) || (state_d != OFF && speed_d != target_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= OFF;
      speed_q  <= '0;
      target_q <= SPEED_W'(TARGET_RST);
      presc_q  <= '0;
      enable_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      speed_q  <= speed_d;
      target_q <= target_d;
      presc_q  <= presc_d;
      enable_q <= enable_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.speed  = speed_q;
  assign bus.enable = enable_q;
  assign bus.target = target_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_pwm_speed_ctrl.sv
// Directed bench for pwm_speed_ctrl with DEB_CYCLES=4, RAMP_DIV=8, TARGET_RST=4.
// Timings are edge counts relative to the start of each scenario, sampled 1ns after the edge.
module tb_pwm_speed_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic ena;

  pwm_speed_ctrl_if bus();

  pwm_speed_ctrl #(
    .DEB_CYCLES(4),
    .RAMP_DIV  (8),
    .TARGET_RST(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ena  (ena),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cur    = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Advance to edge t of the current scenario and settle 1ns past it.
  task automatic go(input int t);
    repeat (t - cur) @(posedge clk);
    #1;
    cur = t;
  endtask

  initial begin
    bus.btn_up  = 1'b0;
    bus.btn_dn  = 1'b0;
    bus.btn_run = 1'b0;
    ena   = 1'b1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check_eq("rst_speed",  bus.speed,  0);
    check_eq("rst_enable", bus.enable, 0);
    check_eq("rst_target", bus.target, 4);
    check_eq("rst_busy",   bus.busy,   0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Soft start from OFF to target 4
    cur = 0;
    bus.btn_run = 1'b1;
    go(6);  check_eq("start_en_before", bus.enable, 0);
    go(7);  check_eq("start_en_after",  bus.enable, 1);
            check_eq("start_busy",      bus.busy,   1);
            check_eq("start_speed0",    bus.speed,  0);
    go(10); bus.btn_run = 1'b0;
    go(14); check_eq("up_hold0", bus.speed, 0);
    go(15); check_eq("up_s1",    bus.speed, 1);
    go(23); check_eq("up_s2",    bus.speed, 2);
    go(31); check_eq("up_s3",    bus.speed, 3);
    go(38); check_eq("up_busy3", bus.busy,  1);
    go(39); check_eq("up_s4",    bus.speed, 4);
            check_eq("run_idle", bus.busy,  0);
    go(45);

    // Two-cycle glitch must be rejected
    cur = 0;
    bus.btn_up = 1'b1;
    go(2);  bus.btn_up = 1'b0;
    go(12); check_eq("glitch_target", bus.target, 4);
            check_eq("glitch_speed",  bus.speed,  4);

    // Five clean presses: target saturates at 7, speed follows
    cur = 0;
    for (int k = 1; k <= 5; k++) begin
      bus.btn_up = 1'b1;
      go(16 * k - 8);
      check_eq($sformatf("press%0d_busy", k), bus.busy, (k <= 3) ? 1 : 0);
      bus.btn_up = 1'b0;
      go(16 * k);
      check_eq($sformatf("press%0d_target", k), bus.target, (4 + k > 7) ? 7 : 4 + k);
      check_eq($sformatf("press%0d_speed", k),  bus.speed,  (4 + k > 7) ? 7 : 4 + k);
    end
    go(86);

    // Soft stop from 7 down to OFF
    cur = 0;
    bus.btn_run = 1'b1;
    go(6);  check_eq("stop_pls_speed", bus.speed,  7);
    go(7);  check_eq("stop_busy",      bus.busy,   1);
            check_eq("stop_speed7",    bus.speed,  7);
    go(8);  bus.btn_run = 1'b0;
    go(14); check_eq("dn_hold7",   bus.speed,  7);
    go(15); check_eq("dn_s6",      bus.speed,  6);
    go(62); check_eq("dn_s1",      bus.speed,  1);
            check_eq("dn_en1",     bus.enable, 1);
    go(63); check_eq("dn_s0",      bus.speed,  0);
            check_eq("off_enable", bus.enable, 0);
            check_eq("off_busy",   bus.busy,   0);
            check_eq("off_target", bus.target, 7);
    go(70);

    // Restart, freeze with ena=0, reverse twice, then reset mid-ramp
    cur = 0;
    bus.btn_run = 1'b1;
    go(7);  check_eq("re_enable", bus.enable, 1);
    go(8);  bus.btn_run = 1'b0;
    go(15); check_eq("re_s1", bus.speed, 1);
    go(19); ena = 1'b0;
    go(45); check_eq("frz_speed",  bus.speed,  1);
            check_eq("frz_target", bus.target, 7);
            check_eq("frz_busy",   bus.busy,   1);
    go(69); ena = 1'b1;
    go(72); check_eq("thaw_hold", bus.speed, 1);
    go(73); check_eq("thaw_s2",   bus.speed, 2);
    go(81); check_eq("thaw_s3",   bus.speed, 3);
    go(84); bus.btn_run = 1'b1;
    go(88); bus.btn_run = 1'b0;
    go(89); check_eq("rev_s4",      bus.speed, 4);
    go(91); check_eq("rdn_speed",   bus.speed, 4);
            check_eq("rdn_busy",    bus.busy,  1);
    go(94); bus.btn_run = 1'b1;
    go(98); bus.btn_run = 1'b0;
            check_eq("rdn_hold4",   bus.speed, 4);
    go(99); check_eq("rdn_s3",      bus.speed, 3);
    go(101); check_eq("rup_speed3", bus.speed,  3);
             check_eq("rup_enable", bus.enable, 1);
             check_eq("rup_busy",   bus.busy,   1);
    go(108); check_eq("rup_hold3",  bus.speed, 3);
    go(109); check_eq("rup_s4",     bus.speed, 4);
    go(117); check_eq("rup_s5",     bus.speed, 5);
    go(120); check_eq("pre_rst_s5", bus.speed, 5);
    rst_n = 1'b0;
    #2;
    check_eq("arst_speed",  bus.speed,  0);
    check_eq("arst_enable", bus.enable, 0);
    check_eq("arst_target", bus.target, 4);
    check_eq("arst_busy",   bus.busy,   0);
    #3 rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
